// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
// Control path for a five-stage RV32I core. The D-stage opcode is decoded into a
// control bundle that travels down the D/E, E/M and M/W registers. Branches are
// resolved in E, and the unit produces the load-use stall, the redirect flush
// and the E-stage forwarding selects.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   opcode_d, funct3_d          D-stage instruction fields
//   rs1_d, rs2_d, rd_d          D-stage register addresses
//   zero_flag, lt_flag, ltu_flag  ALU compare flags for the E instruction
//   imm_src_d, illegal_d        combinational decode outputs
//   alu_src_a_e .. result_src_e E-stage controls (pc_src_e is combinational)
//   result_src_m/_w, mem_write_m, reg_write_m/_w, rd_w  M/W-stage controls
//   forward_a_e, forward_b_e    operand forwarding selects
//   stall_f, stall_d, flush_d, flush_e  hazard controls
module pipeline_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 3,
  parameter bit          EN_FWD     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode_d,
  input  logic [2:0]            funct3_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  zero_flag,
  input  logic                  lt_flag,
  input  logic                  ltu_flag,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic [1:0]            alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic [ALU_OP_W-1:0]   alu_op_e,
  output logic                  pc_src_e,
  output logic                  pc_target_sel_e,
  output logic [1:0]            result_src_e,
  output logic [1:0]            result_src_m,
  output logic [1:0]            result_src_w,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e
);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(2);

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic [1:0]          alu_src_a;
    logic                alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          result_src;
    logic                tsel;
  } ctrl_t;

  ctrl_t                 w_ctrl_d;
  logic [2:0]            w_imm_d;
  logic                  w_ill_d, w_use_rs1, w_use_rs2;

  ctrl_t                 r_ctrl_e;
  logic [REG_ADDR_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;
  logic [2:0]            r_f3_e;
  logic                  r_rw_m, r_mw_m, r_rw_w;
  logic [1:0]            r_res_m, r_res_w;
  logic [REG_ADDR_W-1:0] r_rd_m, r_rd_w;

  logic                  w_cond, w_pc_src, w_match_e, w_match_m, w_hazard, w_stall;

  // Opcode decode; anything undecodable leaves the bundle all-zero (a bubble)
  always_comb begin
    w_ctrl_d  = '0;
    w_imm_d   = 3'b000;
    w_ill_d   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    if (opcode_d[1:0] != 2'b11) begin
      w_ill_d = 1'b1;
    end else begin
      case (opcode_d[6:2])
        5'b00000: begin  // load
          w_ctrl_d.reg_write = 1'b1; w_ctrl_d.alu_src_b = 1'b1; w_ctrl_d.alu_op = ALU_ADD;
          w_ctrl_d.result_src = 2'b01; w_use_rs1 = 1'b1;
        end
        5'b00100: begin  // OP-IMM
          w_ctrl_d.reg_write = 1'b1; w_ctrl_d.alu_src_b = 1'b1; w_ctrl_d.alu_op = ALU_FN;
          w_use_rs1 = 1'b1;
        end
        5'b00101: begin  // AUIPC
          w_ctrl_d.reg_write = 1'b1; w_imm_d = 3'b100; w_ctrl_d.alu_src_a = 2'b01;
          w_ctrl_d.alu_src_b = 1'b1; w_ctrl_d.alu_op = ALU_ADD;
        end
        5'b01000: begin  // store
          w_ctrl_d.mem_write = 1'b1; w_imm_d = 3'b001; w_ctrl_d.alu_src_b = 1'b1;
          w_ctrl_d.alu_op = ALU_ADD; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        end
        5'b01100: begin  // OP
          w_ctrl_d.reg_write = 1'b1; w_ctrl_d.alu_op = ALU_FN;
          w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        end
        5'b01101: begin  // LUI
          w_ctrl_d.reg_write = 1'b1; w_imm_d = 3'b100; w_ctrl_d.alu_src_a = 2'b10;
          w_ctrl_d.alu_src_b = 1'b1; w_ctrl_d.alu_op = ALU_ADD;
        end
        5'b11000: begin  // branch
          w_ctrl_d.branch = 1'b1; w_imm_d = 3'b010; w_ctrl_d.alu_op = ALU_SUB;
          w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        end
        5'b11001: begin  // JALR: target comes from the ALU
          w_ctrl_d.reg_write = 1'b1; w_ctrl_d.jump = 1'b1; w_ctrl_d.alu_src_b = 1'b1;
          w_ctrl_d.alu_op = ALU_ADD; w_ctrl_d.result_src = 2'b10; w_ctrl_d.tsel = 1'b1;
          w_use_rs1 = 1'b1;
        end
        5'b11011: begin  // JAL
          w_ctrl_d.reg_write = 1'b1; w_ctrl_d.jump = 1'b1; w_imm_d = 3'b011;
          w_ctrl_d.result_src = 2'b10;
        end
        default: w_ill_d = 1'b1;
      endcase
    end
  end

  // Branch condition for the E instruction
  always_comb begin
    w_cond = 1'b0;
    case (r_f3_e)
      3'b000:  w_cond = zero_flag;
      3'b001:  w_cond = ~zero_flag;
      3'b100:  w_cond = lt_flag;
      3'b101:  w_cond = ~lt_flag;
      3'b110:  w_cond = ltu_flag;
      3'b111:  w_cond = ~ltu_flag;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_src = r_ctrl_e.jump | (r_ctrl_e.branch & w_cond);

  // RAW matches of the D instruction's used sources against E and M; x0 never matches
  assign w_match_e = (w_use_rs1 & (rs1_d != '0) & (rs1_d == r_rd_e)) |
                     (w_use_rs2 & (rs2_d != '0) & (rs2_d == r_rd_e));
  assign w_match_m = (w_use_rs1 & (rs1_d != '0) & (rs1_d == r_rd_m)) |
                     (w_use_rs2 & (rs2_d != '0) & (rs2_d == r_rd_m));

  // Without forwarding every producer still in E or M must drain first
  assign w_hazard = EN_FWD ? ((r_ctrl_e.result_src == 2'b01) & w_match_e)
                           : ((r_ctrl_e.reg_write & w_match_e) | (r_rw_m & w_match_m));

  // A redirect discards the stalled consumer anyway, so it overrides the stall
  assign w_stall = w_hazard & ~w_pc_src;

  // Forwarding selects, M has priority over W
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (EN_FWD) begin
      if (r_rw_m && (r_rd_m != '0) && (r_rd_m == r_rs1_e))      forward_a_e = 2'b10;
      else if (r_rw_w && (r_rd_w != '0) && (r_rd_w == r_rs1_e)) forward_a_e = 2'b01;
      if (r_rw_m && (r_rd_m != '0) && (r_rd_m == r_rs2_e))      forward_b_e = 2'b10;
      else if (r_rw_w && (r_rd_w != '0) && (r_rd_w == r_rs2_e)) forward_b_e = 2'b01;
    end
  end

  // D/E register; unused source fields are dropped so they cannot raise forwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl_e <= '0;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
      r_f3_e   <= 3'b000;
    end else if (flush_e || w_ill_d) begin
      r_ctrl_e <= '0;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
      r_f3_e   <= 3'b000;
    end else begin
      r_ctrl_e <= w_ctrl_d;
      r_rs1_e  <= w_use_rs1 ? rs1_d : '0;
      r_rs2_e  <= w_use_rs2 ? rs2_d : '0;
      r_rd_e   <= rd_d;
      r_f3_e   <= funct3_d;
    end
  end

  // E/M and M/W registers always advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rw_m  <= 1'b0;
      r_mw_m  <= 1'b0;
      r_res_m <= 2'b00;
      r_rd_m  <= '0;
      r_rw_w  <= 1'b0;
      r_res_w <= 2'b00;
      r_rd_w  <= '0;
    end else begin
      r_rw_m  <= r_ctrl_e.reg_write;
      r_mw_m  <= r_ctrl_e.mem_write;
      r_res_m <= r_ctrl_e.result_src;
      r_rd_m  <= r_rd_e;
      r_rw_w  <= r_rw_m;
      r_res_w <= r_res_m;
      r_rd_w  <= r_rd_m;
    end
  end

  assign imm_src_d       = w_imm_d;
  assign illegal_d       = w_ill_d;
  assign alu_src_a_e     = r_ctrl_e.alu_src_a;
  assign alu_src_b_e     = r_ctrl_e.alu_src_b;
  assign alu_op_e        = r_ctrl_e.alu_op;
  assign pc_src_e        = w_pc_src;
  assign pc_target_sel_e = r_ctrl_e.tsel;
  assign result_src_e    = r_ctrl_e.result_src;
  assign result_src_m    = r_res_m;
  assign result_src_w    = r_res_w;
  assign mem_write_m     = r_mw_m;
  assign reg_write_m     = r_rw_m;
  assign reg_write_w     = r_rw_w;
  assign rd_w            = r_rd_w;
  assign stall_f         = w_stall;
  assign stall_d         = w_stall;
  assign flush_d         = w_pc_src;
  assign flush_e         = w_pc_src | w_hazard;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: the driver issues directed
// instructions and queues the outputs it expects at a given cycle; a monitor
// compares them on the falling edge of that cycle.
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode_d;
  logic [2:0] funct3_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       zero_flag, lt_flag, ltu_flag;
  logic [2:0] imm_src_d;
  logic       illegal_d;
  logic [1:0] alu_src_a_e;
  logic       alu_src_b_e;
  logic [2:0] alu_op_e;
  logic       pc_src_e, pc_target_sel_e;
  logic [1:0] result_src_e, result_src_m, result_src_w;
  logic       mem_write_m, reg_write_m, reg_write_w;
  logic [4:0] rd_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;

  pipeline_control_unit dut (
    .clk(clk), .reset(reset), .opcode_d(opcode_d), .funct3_d(funct3_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag),
    .imm_src_d(imm_src_d), .illegal_d(illegal_d),
    .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e), .alu_op_e(alu_op_e),
    .pc_src_e(pc_src_e), .pc_target_sel_e(pc_target_sel_e),
    .result_src_e(result_src_e), .result_src_m(result_src_m), .result_src_w(result_src_w),
    .mem_write_m(mem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_IMM, F_ILL, F_ASA, F_ASB, F_ALUOP, F_PCSRC, F_TSEL, F_RES_E, F_RES_M, F_RES_W,
    F_MW_M, F_RW_M, F_RW_W, F_RD_W, F_FWDA, F_FWDB, F_STALLF, F_STALLD, F_FLUSHD, F_FLUSHE
  } field_e;

  typedef struct {
    int         cyc;
    field_e     f;
    logic [7:0] val;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tag = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input field_e f);
    case (f)
      F_IMM:    return 8'(imm_src_d);
      F_ILL:    return 8'(illegal_d);
      F_ASA:    return 8'(alu_src_a_e);
      F_ASB:    return 8'(alu_src_b_e);
      F_ALUOP:  return 8'(alu_op_e);
      F_PCSRC:  return 8'(pc_src_e);
      F_TSEL:   return 8'(pc_target_sel_e);
      F_RES_E:  return 8'(result_src_e);
      F_RES_M:  return 8'(result_src_m);
      F_RES_W:  return 8'(result_src_w);
      F_MW_M:   return 8'(mem_write_m);
      F_RW_M:   return 8'(reg_write_m);
      F_RW_W:   return 8'(reg_write_w);
      F_RD_W:   return 8'(rd_w);
      F_FWDA:   return 8'(forward_a_e);
      F_FWDB:   return 8'(forward_b_e);
      F_STALLF: return 8'(stall_f);
      F_STALLD: return 8'(stall_d);
      F_FLUSHD: return 8'(flush_d);
      default:  return 8'(flush_e);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; anything overdue is a miss
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [7:0] got;
        got = observe(sb[i].f);
        n_checks++;
        if (got !== sb[i].val) begin
          n_fail++;
          $display("FAIL test%0d %s cycle %0d: got %0h, required %0h",
                   sb[i].tag, sb[i].f.name(), cyc, got, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL test%0d %s cycle %0d: never sampled", sb[i].tag, sb[i].f.name(), sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int dly, input field_e f, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.f   = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge and present a D instruction
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    @(posedge clk);
    #1;
    opcode_d  = op;
    funct3_d  = f3;
    rs1_d     = r1;
    rs2_d     = r2;
    rd_d      = rd;
    zero_flag = 1'b0;
    lt_flag   = 1'b0;
    ltu_flag  = 1'b0;
  endtask

  task automatic nop();
    issue(7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic exp_pipe_clear();
    exp_at(0, F_ASA, 0);   exp_at(0, F_ASB, 0);   exp_at(0, F_ALUOP, 0);
    exp_at(0, F_PCSRC, 0); exp_at(0, F_TSEL, 0);  exp_at(0, F_RES_E, 0);
    exp_at(0, F_RES_M, 0); exp_at(0, F_RES_W, 0); exp_at(0, F_MW_M, 0);
    exp_at(0, F_RW_M, 0);  exp_at(0, F_RW_W, 0);  exp_at(0, F_RD_W, 0);
    exp_at(0, F_FWDA, 0);  exp_at(0, F_FWDB, 0);  exp_at(0, F_STALLF, 0);
    exp_at(0, F_STALLD, 0); exp_at(0, F_FLUSHD, 0); exp_at(0, F_FLUSHE, 0);
  endtask

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  initial begin
    reset = 1'b0;
    opcode_d = 7'b0010011; funct3_d = 3'b000;
    rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
    zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;

    // Reset state
    tag = 1;
    nop();
    exp_pipe_clear();
    exp_at(0, F_ILL, 0); exp_at(0, F_IMM, 0);
    nop();
    reset = 1'b1;

    // OP: E controls after 1 clk, W after 3
    tag = 2;
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd7);
    exp_at(0, F_IMM, 0); exp_at(0, F_ILL, 0);
    exp_at(1, F_ASB, 0); exp_at(1, F_ALUOP, 2); exp_at(1, F_ASA, 0);
    exp_at(2, F_RW_M, 1);
    exp_at(3, F_RW_W, 1); exp_at(3, F_RD_W, 7); exp_at(3, F_RES_W, 0);
    idle(3);

    // Load x5 then add using x5: one stall cycle, then forward from W
    tag = 3;
    issue(OP_LD, 3'b010, 5'd1, 5'd0, 5'd5);
    exp_at(1, F_STALLF, 1); exp_at(1, F_STALLD, 1); exp_at(1, F_FLUSHE, 1);
    exp_at(1, F_FLUSHD, 0); exp_at(1, F_RES_E, 1);
    issue(OP_R, 3'b000, 5'd5, 5'd2, 5'd6);
    issue(OP_R, 3'b000, 5'd5, 5'd2, 5'd6);
    exp_at(0, F_STALLF, 0); exp_at(0, F_STALLD, 0); exp_at(0, F_FLUSHE, 0);
    exp_at(0, F_RES_E, 0); exp_at(0, F_RES_M, 1); exp_at(0, F_FWDA, 0);
    nop();
    exp_at(0, F_FWDA, 1); exp_at(0, F_FWDB, 0); exp_at(0, F_RES_W, 1); exp_at(0, F_RD_W, 5);
    idle(3);

    // add x3 then sub using x3: forward from M without stalling
    tag = 4;
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd3);
    issue(OP_R, 3'b000, 5'd1, 5'd3, 5'd4);
    exp_at(0, F_STALLD, 0); exp_at(0, F_FLUSHE, 0);
    exp_at(1, F_FWDB, 2); exp_at(1, F_FWDA, 0);
    // Same shape through x0: never forwarded
    tag = 5;
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd0);
    issue(OP_R, 3'b000, 5'd1, 5'd0, 5'd4);
    exp_at(1, F_FWDB, 0); exp_at(1, F_STALLD, 0);
    idle(3);

    // BNE taken with zero_flag=0
    tag = 6;
    issue(OP_BR, 3'b001, 5'd1, 5'd2, 5'd0);
    exp_at(0, F_IMM, 2);
    nop();
    exp_at(0, F_PCSRC, 1); exp_at(0, F_FLUSHD, 1); exp_at(0, F_FLUSHE, 1);
    exp_at(0, F_TSEL, 0); exp_at(0, F_ALUOP, 1); exp_at(0, F_STALLD, 0);
    // BNE not taken with zero_flag=1
    tag = 7;
    issue(OP_BR, 3'b001, 5'd1, 5'd2, 5'd0);
    nop();
    zero_flag = 1'b1;
    exp_at(0, F_PCSRC, 0); exp_at(0, F_FLUSHD, 0); exp_at(0, F_FLUSHE, 0);
    // BLT taken on lt_flag; funct3 010 never taken
    tag = 8;
    issue(OP_BR, 3'b100, 5'd1, 5'd2, 5'd0);
    nop();
    lt_flag = 1'b1;
    exp_at(0, F_PCSRC, 1);
    issue(OP_BR, 3'b010, 5'd1, 5'd2, 5'd0);
    nop();
    zero_flag = 1'b1; lt_flag = 1'b1; ltu_flag = 1'b1;
    exp_at(0, F_PCSRC, 0);
    issue(OP_BR, 3'b111, 5'd1, 5'd2, 5'd0);
    nop();
    ltu_flag = 1'b1;
    exp_at(0, F_PCSRC, 0);
    idle(2);

    // JALR in E with a consumer of its rd in D: redirect, no stall
    tag = 9;
    issue(7'b1100111, 3'b000, 5'd1, 5'd0, 5'd9);
    exp_at(0, F_IMM, 0);
    exp_at(2, F_RES_M, 2);
    exp_at(3, F_RES_W, 2); exp_at(3, F_RW_W, 1); exp_at(3, F_RD_W, 9);
    issue(OP_R, 3'b000, 5'd9, 5'd2, 5'd10);
    exp_at(0, F_PCSRC, 1); exp_at(0, F_TSEL, 1); exp_at(0, F_STALLD, 0);
    exp_at(0, F_STALLF, 0); exp_at(0, F_FLUSHD, 1); exp_at(0, F_FLUSHE, 1);
    nop();
    exp_at(0, F_ALUOP, 0); exp_at(0, F_RES_E, 0);
    idle(2);

    // JAL, LUI, AUIPC, store
    tag = 10;
    issue(7'b1101111, 3'b000, 5'd0, 5'd0, 5'd1);
    exp_at(0, F_IMM, 3);
    exp_at(1, F_PCSRC, 1); exp_at(1, F_TSEL, 0); exp_at(1, F_RES_E, 2);
    nop();
    issue(7'b0110111, 3'b000, 5'd0, 5'd0, 5'd2);
    exp_at(0, F_IMM, 4);
    exp_at(1, F_ASA, 2); exp_at(1, F_ASB, 1); exp_at(1, F_ALUOP, 0);
    issue(7'b0010111, 3'b000, 5'd0, 5'd0, 5'd2);
    exp_at(1, F_ASA, 1);
    issue(7'b0100011, 3'b010, 5'd1, 5'd2, 5'd0);
    exp_at(0, F_IMM, 1);
    exp_at(2, F_MW_M, 1); exp_at(2, F_RW_M, 0);
    idle(3);

    // Illegal opcodes travel as bubbles
    tag = 11;
    issue(7'b0000001, 3'b000, 5'd1, 5'd2, 5'd10);
    exp_at(0, F_ILL, 1); exp_at(0, F_IMM, 0);
    exp_at(1, F_ALUOP, 0); exp_at(1, F_ASB, 0); exp_at(1, F_RES_E, 0); exp_at(1, F_PCSRC, 0);
    exp_at(2, F_RW_M, 0); exp_at(2, F_MW_M, 0);
    exp_at(3, F_RW_W, 0);
    issue(7'b0110001, 3'b000, 5'd1, 5'd2, 5'd10);
    exp_at(0, F_ILL, 1);
    idle(3);

    // Reset asserted with a full pipeline clears everything at once
    tag = 12;
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd7);
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd7);
    issue(OP_R, 3'b000, 5'd1, 5'd2, 5'd7);
    nop();
    reset = 1'b0;
    #1;
    exp_pipe_clear();
    nop();
    reset = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
